// File: rtl/seg_scan_if.sv
// Bundle of update and display signals for seg_scan_driver.
//   master : UI side, drives load/disp_data/blink_mask/dp_mask/scroll_en and
//            observes seg_out/an_out/busy.
//   slave  : the scan driver itself.
// DIGITS must match the DIGITS of the driver it is connected to.
interface seg_scan_if #(
  parameter int DIGITS = 8
) ();
  logic                  load;
  logic [4*DIGITS-1:0]   disp_data;
  logic [DIGITS-1:0]     blink_mask;
  logic [DIGITS-1:0]     dp_mask;
  logic                  scroll_en;
  logic [7:0]            seg_out;
  logic [DIGITS-1:0]     an_out;
  logic                  busy;

  modport master (
    output load, disp_data, blink_mask, dp_mask, scroll_en,
    input  seg_out, an_out, busy
  );

  modport slave (
    input  load, disp_data, blink_mask, dp_mask, scroll_en,
    output seg_out, an_out, busy
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-aligned updates,
// per-digit blink and decimal point, and rotating scroll.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : seg_scan_if.slave
//             load/disp_data/blink_mask/dp_mask : update strobe and payload
//             scroll_en                         : rotate view once per SCROLL_FRAMES
//             seg_out {a..g,dp}, an_out one-hot : registered pin drive
//             busy                              : captured update awaiting frame end
module seg_scan_driver #(
  parameter int DIGITS        = 8,
  parameter int SCAN_DIV      = 100000,
  parameter int BLINK_FRAMES  = 64,
  parameter int SCROLL_FRAMES = 128
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_FRAMES - 1);
  localparam logic [IW:0]   DIGITS_W    = (IW + 1)'(DIGITS);

  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic [SW-1:0]         scroll_cnt;
  logic [IW-1:0]         offset;
  logic [4*DIGITS-1:0]   act_data, pend_data;
  logic [DIGITS-1:0]     act_blink, pend_blink;
  logic [DIGITS-1:0]     act_dp, pend_dp;
  logic                  busy_q;
  logic [7:0]            seg_q;
  logic [DIGITS-1:0]     an_q;

  logic                  tick;
  logic                  frame_end;
  logic [IW-1:0]         eff_off;
  logic [IW:0]           pos_sum;
  logic [IW-1:0]         pos;
  logic [3:0]            glyph;
  logic [7:0]            seg_next;

  function automatic logic [7:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 8'hFC;
      4'h1: decode = 8'h60;
      4'h2: decode = 8'hDA;
      4'h3: decode = 8'hF2;
      4'h4: decode = 8'h0A;
      4'h5: decode = 8'hB6;
      4'h6: decode = 8'h6E;
      4'h7: decode = 8'h1C;
      4'h8: decode = 8'h38;
      4'h9: decode = 8'h1E;
      4'hA: decode = 8'hEE;
      4'hB: decode = 8'h3A;
      4'hC: decode = 8'h9C;
      4'hD: decode = 8'h00;
      4'hE: decode = 8'h9E;
      default: decode = 8'h8E;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Offset is gated by scroll_en so that dropping scroll shows the
  // unrotated view on the very next registered output.
  always_comb begin
    eff_off = bus.scroll_en ? offset : '0;
    pos_sum = {1'b0, idx} + {1'b0, eff_off};
    if (pos_sum >= DIGITS_W) pos_sum = pos_sum - DIGITS_W;
    pos   = pos_sum[IW-1:0];
    glyph = act_data[{pos, 2'b00} +: 4];
    seg_next = decode(glyph) | {7'b0, act_dp[pos]};
    if (blink_phase && act_blink[pos]) seg_next = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      scroll_cnt  <= '0;
      offset      <= '0;
      act_data    <= {DIGITS{4'hD}};
      pend_data   <= {DIGITS{4'hD}};
      act_blink   <= '0;
      pend_blink  <= '0;
      act_dp      <= '0;
      pend_dp     <= '0;
      busy_q      <= 1'b0;
      seg_q       <= 8'h00;
      an_q        <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      if (frame_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      if (!bus.scroll_en) begin
        scroll_cnt <= '0;
        offset     <= '0;
      end else if (frame_end) begin
        if (scroll_cnt == SCROLL_LAST) begin
          scroll_cnt <= '0;
          offset     <= (offset == IDX_LAST) ? '0 : offset + 1'b1;
        end else begin
          scroll_cnt <= scroll_cnt + 1'b1;
        end
      end

      // A load landing on frame_end bypasses pending; it is newer than
      // anything already pending, so it wins.
      if (bus.load && frame_end) begin
        act_data  <= bus.disp_data;
        act_blink <= bus.blink_mask;
        act_dp    <= bus.dp_mask;
        busy_q    <= 1'b0;
      end else if (bus.load) begin
        pend_data  <= bus.disp_data;
        pend_blink <= bus.blink_mask;
        pend_dp    <= bus.dp_mask;
        busy_q     <= 1'b1;
      end else if (frame_end && busy_q) begin
        act_data  <= pend_data;
        act_blink <= pend_blink;
        act_dp    <= pend_dp;
        busy_q    <= 1'b0;
      end

      an_q  <= {{(DIGITS-1){1'b0}}, 1'b1} << idx;
      seg_q <= seg_next;
    end
  end

  assign bus.seg_out = seg_q;
  assign bus.an_out  = an_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;

  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(4)) ifa ();
  seg_scan_if #(.DIGITS(6)) ifb ();

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .SCROLL_FRAMES(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa.slave)
  );

  seg_scan_driver #(.DIGITS(6), .SCAN_DIV(2), .BLINK_FRAMES(2), .SCROLL_FRAMES(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge following post-release posedge number e.
  task automatic go(input int e);
    while (ecnt < e) begin
      @(negedge clk);
      ecnt++;
    end
  endtask

  task automatic a_digit(input string tag, input int e, input logic [3:0] an, input logic [7:0] seg);
    go(e);
    chk({tag, "_an"}, 32'(ifa.an_out), 32'(an));
    chk({tag, "_seg"}, 32'(ifa.seg_out), 32'(seg));
  endtask

  task automatic b_digit(input string tag, input int e, input logic [5:0] an, input logic [7:0] seg);
    go(e);
    chk({tag, "_an"}, 32'(ifb.an_out), 32'(an));
    chk({tag, "_seg"}, 32'(ifb.seg_out), 32'(seg));
  endtask

  task automatic a_load(input logic [15:0] d, input logic [3:0] bm, input logic [3:0] dm);
    ifa.load = 1'b1; ifa.disp_data = d; ifa.blink_mask = bm; ifa.dp_mask = dm;
    go(ecnt + 1);
    ifa.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.load = 1'b0; ifa.disp_data = '0; ifa.blink_mask = '0; ifa.dp_mask = '0; ifa.scroll_en = 1'b0;
    ifb.load = 1'b0; ifb.disp_data = '0; ifb.blink_mask = '0; ifb.dp_mask = '0; ifb.scroll_en = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset state and scan order
    chk("rst_seg", 32'(ifa.seg_out), 32'h00);
    chk("rst_an", 32'(ifa.an_out), 32'h0);
    chk("rst_busy", 32'(ifa.busy), 32'h0);
    rst_a = 1'b1;
    ecnt = 0;
    a_digit("scan0", 1, 4'b0001, 8'h00);
    a_digit("scan0_hold", 4, 4'b0001, 8'h00);
    a_digit("scan1", 5, 4'b0010, 8'h00);
    a_digit("scan2", 9, 4'b0100, 8'h00);
    a_digit("scan3", 13, 4'b1000, 8'h00);
    a_digit("scan_wrap", 17, 4'b0001, 8'h00);

    // 2: mid-frame load commits at frame end, no tearing
    go(20);
    a_load(16'hF321, 4'b0000, 4'b0000);
    chk("ld_busy", 32'(ifa.busy), 32'h1);
    a_digit("ld_old_d1", 22, 4'b0010, 8'h00);
    a_digit("ld_old_d3", 30, 4'b1000, 8'h00);
    chk("ld_busy_hold", 32'(ifa.busy), 32'h1);
    a_digit("ld_fe_out", 32, 4'b1000, 8'h00);
    chk("ld_commit_busy", 32'(ifa.busy), 32'h0);
    a_digit("ld_d0", 33, 4'b0001, 8'h60);
    a_digit("ld_d1", 37, 4'b0010, 8'hDA);
    a_digit("ld_d2", 41, 4'b0100, 8'hF2);
    a_digit("ld_d3", 45, 4'b1000, 8'h8E);

    // 3: last load wins; load on frame_end goes straight to active
    go(50);
    a_load(16'h1111, 4'b0000, 4'b0000);
    chk("ld2_busy", 32'(ifa.busy), 32'h1);
    go(54);
    a_load(16'h2222, 4'b0000, 4'b0000);
    a_digit("ld2_old", 58, 4'b0100, 8'hF2);
    a_digit("ld2_d0", 65, 4'b0001, 8'hDA);
    a_digit("ld2_d3", 77, 4'b1000, 8'hDA);
    go(79);
    a_load(16'hE0A5, 4'b0000, 4'b0000);
    chk("fe_ld_busy", 32'(ifa.busy), 32'h0);
    chk("fe_ld_oldout", 32'(ifa.seg_out), 32'hDA);
    a_digit("fe_ld_d0", 81, 4'b0001, 8'hB6);
    a_digit("fe_ld_d1", 85, 4'b0010, 8'hEE);
    a_digit("fe_ld_d3", 93, 4'b1000, 8'h9E);

    // 4: blink on digit0, dp on digit3; phase 1 in frames 2,3,6,7,10,11
    go(98);
    a_load(16'h0000, 4'b0001, 4'b1000);
    a_digit("bl_f7_d0", 113, 4'b0001, 8'h00);
    a_digit("bl_f7_d1", 117, 4'b0010, 8'hFC);
    a_digit("bl_f7_d3", 125, 4'b1000, 8'hFD);
    a_digit("bl_f8_d0", 129, 4'b0001, 8'hFC);
    a_digit("bl_f9_d0", 145, 4'b0001, 8'hFC);
    a_digit("bl_f10_d0", 161, 4'b0001, 8'h00);
    a_digit("bl_f10_d3", 173, 4'b1000, 8'hFD);
    a_digit("bl_f12_d0", 193, 4'b0001, 8'hFC);

    // 5: scroll
    go(194);
    a_load(16'h3210, 4'b0000, 4'b0000);
    go(209);
    ifa.scroll_en = 1'b1;
    a_digit("sc_f13_d0", 210, 4'b0001, 8'hFC);
    a_digit("sc_f14_d0", 226, 4'b0001, 8'h60);
    a_digit("sc_f14_d3", 238, 4'b1000, 8'hFC);
    a_digit("sc_f15_d0", 242, 4'b0001, 8'hDA);
    a_digit("sc_f16_d0", 258, 4'b0001, 8'hF2);
    a_digit("sc_f17_d0", 274, 4'b0001, 8'hFC);
    a_digit("sc_f18_d0", 290, 4'b0001, 8'h60);
    ifa.scroll_en = 1'b0;
    a_digit("sc_off_d0", 291, 4'b0001, 8'hFC);
    go(292);
    ifa.scroll_en = 1'b1;
    a_digit("sc_re_d0", 306, 4'b0001, 8'h60);
    go(308);
    a_load(16'h8888, 4'b0000, 4'b0000);
    chk("sc_pend_busy", 32'(ifa.busy), 32'h1);
    go(310);
    rst_a = 1'b0;
    go(312);
    chk("mrst_seg", 32'(ifa.seg_out), 32'h00);
    chk("mrst_an", 32'(ifa.an_out), 32'h0);
    chk("mrst_busy", 32'(ifa.busy), 32'h0);
    rst_a = 1'b1;
    ecnt = 0;
    a_digit("mrst_f0_d0", 1, 4'b0001, 8'h00);
    go(2);
    a_load(16'h3210, 4'b0000, 4'b0000);
    a_digit("mrst_f0_d1", 5, 4'b0010, 8'h00);
    a_digit("mrst_f1_d0", 17, 4'b0001, 8'h60);

    // 6: DIGITS=6, SCAN_DIV=2, non-power-of-two wrap
    go(20);
    chk("b_rst_an", 32'(ifb.an_out), 32'h0);
    rst_b = 1'b1;
    ecnt = 0;
    b_digit("b_d0", 1, 6'b000001, 8'h00);
    go(2);
    ifb.load = 1'b1; ifb.disp_data = 24'h543210;
    go(3);
    ifb.load = 1'b0;
    b_digit("b_d5", 11, 6'b100000, 8'h00);
    b_digit("b_wrap", 13, 6'b000001, 8'hFC);
    ifb.scroll_en = 1'b1;
    b_digit("b_f1_d5", 23, 6'b100000, 8'hB6);
    b_digit("b_f3_d4", 45, 6'b010000, 8'hFC);
    b_digit("b_f6_d0", 73, 6'b000001, 8'hB6);
    b_digit("b_f6_d1", 75, 6'b000010, 8'hFC);
    b_digit("b_f6_d5", 83, 6'b100000, 8'h0A);
    b_digit("b_f7_d0", 85, 6'b000001, 8'hFC);
    b_digit("b_f7_d3", 91, 6'b001000, 8'hF2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
